// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl encodings, FSM states and the default data width.
// Used by alu_mc, alu_mul_seq and the ALU controller.
package alu_pkg;

    localparam int unsigned DataWDefault = 32;

    typedef enum logic [3:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluMul = 4'b0011,
        AluSub = 4'b0110,
        AluSlt = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } alu_state_e;

    function automatic logic is_mul(logic [3:0] ctrl);
        return ctrl == AluMul;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath: one multiplier bit per step, low DATA_W bits kept.
// MUL_EARLY_TERM_EN: also flag the last step once the shifted multiplier is zero.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic [DATA_W-1:0] acc_next_o,
    output logic              last_o
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_add;
    logic [DATA_W-1:0] mplier_shift;

    always_comb begin
        acc_add      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift = mplier_q >> 1;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_add;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + CntW'(1);
        end
    end

    // The owner copies acc_next_o on the step where last_o is high, so the final add counts.
    assign acc_next_o = acc_add;
`ifdef MUL_EARLY_TERM_EN
    assign last_o = (cnt_q == CntW'(DATA_W - 1)) || (mplier_shift == '0);
`else
    assign last_o = (cnt_q == CntW'(DATA_W - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus a sequential shift-add multiply.
// MUL_EARLY_TERM_EN (in alu_mul_seq) shortens multiplies with small multipliers.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] single_res;
    logic              mul_load;
    logic              mul_step;
    logic [DATA_W-1:0] mul_acc_next;
    logic              mul_last;

    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            AluAnd:  single_res = src1_i & src2_i;
            AluOr:   single_res = src1_i | src2_i;
            AluAdd:  single_res = src1_i + src2_i;
            AluSub:  single_res = src1_i - src2_i;
            AluSlt:  single_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (is_mul(ALUCtrl_i)) begin
                        mul_load = 1'b1;
                        state_d  = StMul;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_acc_next;
                    zero_d   = (mul_acc_next == '0);
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    alu_mul_seq #(
        .DATA_W(DATA_W)
    ) u_mul_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (mul_load),
        .step_i     (mul_step),
        .mcand_i    (src1_i),
        .mplier_i   (src2_i),
        .acc_next_o (mul_acc_next),
        .last_o     (mul_last)
    );

    assign ready_o  = (state_q == StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule
